// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, NOP constant
// and the register-match helper used by the load-use detector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } ctrl_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // x0 is hardwired to zero, so a load into it never creates a dependency
  function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] rs, input logic used);
    return used && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs and stall/flush controls exchanged between the pipeline
// datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       IF_ID_Rs1;
  logic [4:0]       IF_ID_Rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_Rd;
  logic             ex_mispredict;
  logic             imem_ready;
  logic             EX_MEM_MemRead;
  logic             EX_MEM_MemWrite;
  logic             dmem_ready;

  logic             pc_write;
  logic             pc_redirect;
  logic             IF_ID_Stall;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             Control_Sig_Stall;
  logic             mem_hold;
  logic             mem_timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output IF_ID_Rs1, IF_ID_Rs2, id_use_rs1, id_use_rs2, ID_EX_MemRead, ID_EX_Rd,
           ex_mispredict, imem_ready, EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
    input  pc_write, pc_redirect, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush,
           Control_Sig_Stall, mem_hold, mem_timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  IF_ID_Rs1, IF_ID_Rs2, id_use_rs1, id_use_rs2, ID_EX_MemRead, ID_EX_Rd,
           ex_mispredict, imem_ready, EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready,
    output pc_write, pc_redirect, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush,
           Control_Sig_Stall, mem_hold, mem_timeout_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; the active-low
// clear is synchronous and takes priority over the increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_clr_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: Mealy-decoded controls
// from a BOOT/RUN/MEM_WAIT FSM, plus saturating perf counters and dmem timeout.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_PRE  = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       r_state;
  logic [BOOT_W-1:0] r_bootCnt;
  logic              r_timeoutErr;

  logic              w_inBoot;
  logic              w_dmemBusy;
  logic              w_loadUse;
  logic              w_holding;
  logic              w_pcWrite;
  logic              w_pcRedirect;
  logic              w_ifIdStall;
  logic              w_ifIdFlush;
  logic              w_idExFlush;
  logic              w_ctrlStall;
  logic              w_memHold;
  logic              w_stallInc;
  logic              w_waitClrN;
  logic              w_waitInc;
  logic [WAIT_W-1:0] w_waitCnt;
  logic [CNT_W-1:0]  w_stallCnt;
  logic [CNT_W-1:0]  w_flushCnt;

  assign w_inBoot   = !reset || (r_state == ST_BOOT);
  assign w_dmemBusy = (bus.EX_MEM_MemRead || bus.EX_MEM_MemWrite) && !bus.dmem_ready;
  assign w_loadUse  = bus.ID_EX_MemRead &&
                      (regMatch(bus.ID_EX_Rd, bus.IF_ID_Rs1, bus.id_use_rs1) ||
                       regMatch(bus.ID_EX_Rd, bus.IF_ID_Rs2, bus.id_use_rs2));
  assign w_holding  = !w_inBoot && ((r_state == ST_MEM_WAIT) || w_dmemBusy);

  // Memory hold outranks the mispredict so the branch is re-seen once released
  always_comb begin
    w_pcWrite    = 1'b0;
    w_pcRedirect = 1'b0;
    w_ifIdStall  = 1'b0;
    w_ifIdFlush  = 1'b0;
    w_idExFlush  = 1'b0;
    w_ctrlStall  = 1'b0;
    w_memHold    = 1'b0;
    if (w_inBoot) begin
      w_ifIdFlush = 1'b1;
      w_idExFlush = 1'b1;
    end else if (w_holding) begin
      w_ifIdStall = 1'b1;
      w_ctrlStall = 1'b1;
      w_memHold   = 1'b1;
    end else if (bus.ex_mispredict) begin
      w_pcWrite    = 1'b1;
      w_pcRedirect = 1'b1;
      w_ifIdFlush  = 1'b1;
      w_idExFlush  = 1'b1;
    end else if (w_loadUse) begin
      w_ifIdStall = 1'b1;
      w_idExFlush = 1'b1;
    end else if (!bus.imem_ready) begin
      w_ifIdFlush = 1'b1;
    end else begin
      w_pcWrite = 1'b1;
    end
  end

  assign w_stallInc = !w_inBoot && !w_pcWrite;
  // Wait count survives only across uninterrupted wait cycles; release clears it
  assign w_waitClrN = w_holding && !((r_state == ST_MEM_WAIT) && bus.dmem_ready);
  assign w_waitInc  = w_waitClrN && (w_waitCnt != WAIT_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_BOOT;
      r_bootCnt    <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      if (w_waitInc && (w_waitCnt == WAIT_PRE)) begin
        r_timeoutErr <= 1'b1;
      end
      case (r_state)
        ST_BOOT: begin
          if (r_bootCnt == BOOT_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_bootCnt <= r_bootCnt + BOOT_W'(1);
          end
        end
        ST_RUN: begin
          if (w_dmemBusy) begin
            r_state <= ST_MEM_WAIT;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.dmem_ready) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
    .clk     (clk),
    .i_clr_n (reset),
    .i_inc   (w_stallInc),
    .o_count (w_stallCnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flushCnt (
    .clk     (clk),
    .i_clr_n (reset),
    .i_inc   (w_pcRedirect),
    .o_count (w_flushCnt)
  );

  sat_counter #(.WIDTH(WAIT_W)) u_waitCnt (
    .clk     (clk),
    .i_clr_n (w_waitClrN),
    .i_inc   (w_waitInc),
    .o_count (w_waitCnt)
  );

  assign bus.pc_write          = w_pcWrite;
  assign bus.pc_redirect       = w_pcRedirect;
  assign bus.IF_ID_Stall       = w_ifIdStall;
  assign bus.IF_ID_Flush       = w_ifIdFlush;
  assign bus.ID_EX_Flush       = w_idExFlush;
  assign bus.Control_Sig_Stall = w_ctrlStall;
  assign bus.mem_hold          = w_memHold;
  assign bus.mem_timeout_err   = r_timeoutErr;
  assign bus.stall_cnt         = w_stallCnt;
  assign bus.flush_cnt         = w_flushCnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: inputs change on the falling edge,
// controls are compared mid-cycle against hand-computed vectors.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  // {pc_write, pc_redirect, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, Control_Sig_Stall, mem_hold}
  localparam logic [6:0] C_BOOT = 7'b0001100;
  localparam logic [6:0] C_RUN  = 7'b1000000;
  localparam logic [6:0] C_LU   = 7'b0010100;
  localparam logic [6:0] C_MISP = 7'b1101100;
  localparam logic [6:0] C_IMEM = 7'b0001000;
  localparam logic [6:0] C_HOLD = 7'b0010011;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checkCnt = 0;
  int   passCnt  = 0;
  int   failCnt  = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .BOOT_CYCLES (2),
    .MEM_TIMEOUT (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rstN, input logic exLoad, input logic [4:0] exRd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic use1, input logic use2, input logic misp,
                               input logic imemRdy, input logic memRd, input logic memWr,
                               input logic dmemRdy);
    @(negedge clk);
    reset               = rstN;
    bus.ID_EX_MemRead   = exLoad;
    bus.ID_EX_Rd        = exRd;
    bus.IF_ID_Rs1       = rs1;
    bus.IF_ID_Rs2       = rs2;
    bus.id_use_rs1      = use1;
    bus.id_use_rs2      = use2;
    bus.ex_mispredict   = misp;
    bus.imem_ready      = imemRdy;
    bus.EX_MEM_MemRead  = memRd;
    bus.EX_MEM_MemWrite = memWr;
    bus.dmem_ready      = dmemRdy;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCnt++;
    assert (observed === expected) passCnt++;
    else begin
      failCnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic [6:0] expected);
    logic [6:0] obs;
    logic       bad;
    obs = {bus.pc_write, bus.pc_redirect, bus.IF_ID_Stall, bus.IF_ID_Flush,
           bus.ID_EX_Flush, bus.Control_Sig_Stall, bus.mem_hold};
    bad = (bus.IF_ID_Flush && bus.IF_ID_Stall) || (bus.ID_EX_Flush && bus.Control_Sig_Stall) ||
          (bus.pc_redirect && !bus.pc_write);
    checkOutput(tag, 32'(obs), 32'(expected));
    checkOutput({tag, "_inv"}, 32'(bad), 32'd0);
  endtask

  task automatic checkCounters(input string tag, input int stalls, input int flushes, input logic err);
    checkOutput({tag, "_stall"}, bus.stall_cnt, 32'(stalls));
    checkOutput({tag, "_flush"}, bus.flush_cnt, 32'(flushes));
    checkOutput({tag, "_err"}, 32'(bus.mem_timeout_err), 32'(err));
  endtask

  initial begin
    $display("[TB] start");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkCtrl("rst_ctrl", C_BOOT);
    end
    checkCounters("rst", 0, 0, 1'b0);

    idleCycle();
    checkCtrl("boot1", C_BOOT);
    idleCycle();
    checkCtrl("boot2", C_BOOT);
    idleCycle();
    checkCtrl("run1", C_RUN);
    checkCounters("after_boot", 0, 0, 1'b0);

    applyStimulus(1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkCtrl("loaduse_rs2", C_LU);
    idleCycle();
    checkCtrl("loaduse_done", C_RUN);
    checkCounters("loaduse", 1, 0, 1'b0);

    applyStimulus(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkCtrl("loaduse_x0", C_RUN);
    applyStimulus(1'b1, 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkCtrl("loaduse_rs1_imem", C_LU);
    idleCycle();
    checkCounters("x0_rs1", 2, 0, 1'b0);

    applyStimulus(1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkCtrl("misp_loaduse", C_MISP);
    idleCycle();
    checkCounters("misp", 2, 1, 1'b0);

    applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkCtrl("imem_wait1", C_IMEM);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkCtrl("imem_wait2", C_IMEM);
    idleCycle();
    checkCounters("imem", 4, 1, 1'b0);

    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      checkCtrl("store_wait", C_HOLD);
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkCtrl("store_release", C_HOLD);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkCtrl("store_redirect", C_MISP);
    checkCounters("store_mid", 9, 1, 1'b0);
    idleCycle();
    checkCounters("store", 9, 2, 1'b0);

    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkCtrl("timeout_wait", C_HOLD);
      if (k == 7) checkOutput("timeout_early", 32'(bus.mem_timeout_err), 32'd0);
      if (k >= 9) checkOutput("timeout_set", 32'(bus.mem_timeout_err), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkCtrl("timeout_release", C_HOLD);
    idleCycle();
    checkCtrl("timeout_run", C_RUN);
    checkCounters("timeout", 20, 2, 1'b1);
    idleCycle();
    checkOutput("timeout_sticky", 32'(bus.mem_timeout_err), 32'd1);

    applyStimulus(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkCtrl("rerst_ctrl", C_BOOT);
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkCounters("rerst", 0, 0, 1'b0);
    idleCycle();
    checkCtrl("rerst_boot", C_BOOT);

    $display("[TB] %0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline. It generates the IF/ID, ID/EX and PC enables and flushes, and the new hold enable for the EX/MEM and MEM/WB registers. Inputs are load-use hazards, EX-stage branch mispredicts, instruction-fetch waits and multi-cycle data-memory handshakes. It also keeps saturating stall/flush performance counters and flags data-memory timeouts.

Parameters:
BOOT_CYCLES, 2, cycles after reset during which the pipeline is held and flushed
MEM_TIMEOUT, 64, consecutive dmem wait cycles before mem_timeout_err sets
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-low reset
IF_ID_Rs1  in  5  rs1 of instruction in ID
IF_ID_Rs2  in  5  rs2 of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ID_EX_MemRead  in  1  load in EX
ID_EX_Rd  in  5  rd of instruction in EX
ex_mispredict  in  1  EX branch/jump resolved against prediction (wrong or invalid prediction)
imem_ready  in  1  fetch data valid this cycle
EX_MEM_MemRead  in  1  load in MEM
EX_MEM_MemWrite  in  1  store in MEM
dmem_ready  in  1  data memory completes this cycle
pc_write  out  1  PC register enable
pc_redirect  out  1  select EX-resolved target for PC
IF_ID_Stall  out  1  hold IF/ID
IF_ID_Flush  out  1  load NOP into IF/ID
ID_EX_Flush  out  1  load bubble into ID/EX
Control_Sig_Stall  out  1  hold ID/EX
mem_hold  out  1  hold EX/MEM and MEM/WB
mem_timeout_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  cycles with pc_write==0 (excludes BOOT)
flush_cnt  out  CNT_W  mispredict flushes

Behaviour:
- FSM states: BOOT, RUN, MEM_WAIT. All outputs are Mealy-decoded from the current state and inputs, so they take effect in the same cycle. State and counters are registered.
- Reset (reset==0 at posedge): state=BOOT, boot counter=0, wait counter=0, stall_cnt=0, flush_cnt=0, mem_timeout_err=0.
- Output values during reset and in BOOT: pc_write=0, IF_ID_Flush=1, ID_EX_Flush=1, all others 0.
- BOOT: lasts exactly BOOT_CYCLES cycles, then RUN. Reset asserted in any state returns to BOOT on the next posedge.
- RUN priority, highest first; each cycle applies only the highest active case:
  1. dmem busy = (EX_MEM_MemRead|EX_MEM_MemWrite) && !dmem_ready. Drive pc_write=0, IF_ID_Stall=1, Control_Sig_Stall=1, mem_hold=1, no flushes, ex_mispredict ignored. Go to MEM_WAIT with wait counter=1. The mispredicting branch stays held in EX and is re-seen after release.
  2. ex_mispredict: pc_write=1, pc_redirect=1, IF_ID_Flush=1, ID_EX_Flush=1. Any load-use or imem wait in the same cycle is ignored because that instruction is wrong-path. flush_cnt increments.
  3. load-use = ID_EX_MemRead && ID_EX_Rd!=0 && ((ID_EX_Rd==IF_ID_Rs1 && id_use_rs1) || (ID_EX_Rd==IF_ID_Rs2 && id_use_rs2)). Drive pc_write=0, IF_ID_Stall=1, ID_EX_Flush=1 (one bubble). The stall lasts one cycle, since the bubble clears the hazard. IF_ID_Flush=0 even when imem_ready=0.
  4. !imem_ready: pc_write=0, IF_ID_Flush=1 (NOP), IF_ID_Stall=0.
  5. Otherwise: pc_write=1, all other control outputs 0.
- MEM_WAIT: drive the case-1 outputs every cycle.
  - When dmem_ready=1, the outputs still hold that cycle; return to RUN next cycle and clear the wait counter.
  - The wait counter increments and saturates at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, mem_timeout_err sets and stays set until reset. The FSM keeps waiting.
- Invariants:
  - IF_ID_Flush and IF_ID_Stall are never both 1.
  - ID_EX_Flush and Control_Sig_Stall are never both 1.
  - pc_redirect=1 only when pc_write=1.
- Counters saturate at all-ones and never wrap. stall_cnt increments in RUN/MEM_WAIT cycles where pc_write==0.

Decomposition:
- Shared package pipe_ctrl_pkg holds the FSM state encoding (BOOT/RUN/MEM_WAIT, 2 bits) and the NOP constant 32'h00000013.
- One sub-module, sat_counter (parameter width, inc, synchronous active-low clear), instantiated for stall_cnt, flush_cnt and the wait counter.

Test Plan:
- Reset low 3 cycles, then release: pc_write=0 and both flushes=1 for exactly 2 cycles after release; then pc_write=1 and all counters 0.
- Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, IF_ID_Rs2=5, id_use_rs2=1 for 1 cycle -> pc_write=0, IF_ID_Stall=1, ID_EX_Flush=1 that cycle; stall_cnt=1. Repeat with ID_EX_Rd=0 -> no stall.
- Mispredict and load-use in the same cycle: -> pc_redirect=1, both flushes=1, IF_ID_Stall=0, flush_cnt=1.
- Store in MEM with dmem_ready=0 for 4 cycles then 1, ex_mispredict=1 throughout: mem_hold=1 for 5 cycles with no flush; redirect asserts the cycle after release.
- With MEM_TIMEOUT=8, dmem_ready held low for 10 cycles: mem_timeout_err rises on the 8th wait cycle and stays 1 after dmem_ready=1 until reset.
- imem_ready=0 for 2 cycles with no other hazard: IF_ID_Flush=1 and pc_write=0 each cycle; stall_cnt +=2.
